clk_edge_tick: RTL

CLK_EDGE_TICK -- requirements
Module: clk_edge_tick

---
 rtl/clk_edge_tick.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/clk_edge_tick.sv
// clk_edge_tick: synchronizes a divided slow clock into the clk_in domain,
// emits one-cycle rise/fall ticks, measures the rise-to-rise period in clk_in
// cycles and tracks whether successive periods agree (lock) or whether the
// slow clock has stopped (loss).
module clk_edge_tick #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT     = 256,
  parameter int TOL         = 1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                slow_clk,
  input  logic                enable,
  output logic                rise_tick,
  output logic                fall_tick,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                timeout
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FIRST = 3'd1,
    MEASURE    = 3'd2,
    LOCKED     = 3'd3,
    LOST       = 3'd4
  } state_t;

  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX   = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W:0]   TOL_V     = (PERIOD_W + 1)'(TOL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  state_t                 state_q;
  logic [PERIOD_W-1:0]    cnt_q;
  logic [PERIOD_W-1:0]    period_q;
  logic                   prev_valid_q;
  logic                   rise_tick_q;
  logic                   fall_tick_q;
  logic                   period_valid_q;
  logic                   locked_q;
  logic                   timeout_q;

  logic                   sync_last;
  logic                   rise_ev;
  logic                   fall_ev;
  logic [PERIOD_W-1:0]    cnt_d;
  logic [PERIOD_W:0]      cur_ext;
  logic [PERIOD_W:0]      prev_ext;
  logic [PERIOD_W:0]      diff_d;
  logic                   match;
  logic                   expired;

  // Edge events compare the newest synchronized sample with the one before it.
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise_ev   = sync_last & ~hist_q;
  assign fall_ev   = ~sync_last & hist_q;

  // Interval counter saturates so a very long gap reports the max value.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Magnitude of the period change, one bit wider so it never wraps.
  assign cur_ext  = {1'b0, cnt_q};
  assign prev_ext = {1'b0, period_q};
  assign diff_d   = (cur_ext >= prev_ext) ? (cur_ext - prev_ext) : (prev_ext - cur_ext);
  assign match    = (diff_d <= TOL_V);
  assign expired  = (cnt_q >= TIMEOUT_V);

  // Synchronizer chain and history flop run independently of enable.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      hist_q <= sync_last;
    end
  end

  // Registered edge ticks, muted while the block is idle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      rise_tick_q <= rise_ev && (state_q != IDLE);
      fall_tick_q <= fall_ev && (state_q != IDLE);
    end
  end

  // Measurement / lock / loss state machine with registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      prev_valid_q   <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      cnt_q          <= cnt_d;
      if (!enable) begin
        // Disable wins over everything, including a coincident rise.
        state_q      <= IDLE;
        cnt_q        <= CNT_ONE;
        prev_valid_q <= 1'b0;
        locked_q     <= 1'b0;
        timeout_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // Counter restarts so the first-edge wait is also bounded.
            state_q <= WAIT_FIRST;
            cnt_q   <= CNT_ONE;
          end
          WAIT_FIRST: begin
            if (rise_ev) begin
              state_q <= MEASURE;
              cnt_q   <= CNT_ONE;
            end else if (expired) begin
              state_q      <= LOST;
              timeout_q    <= 1'b1;
              prev_valid_q <= 1'b0;
            end
          end
          MEASURE: begin
            if (rise_ev) begin
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              prev_valid_q   <= 1'b1;
              cnt_q          <= CNT_ONE;
              if (prev_valid_q && match) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (expired) begin
              state_q      <= LOST;
              timeout_q    <= 1'b1;
              prev_valid_q <= 1'b0;
            end
          end
          LOCKED: begin
            if (rise_ev) begin
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              prev_valid_q   <= 1'b1;
              cnt_q          <= CNT_ONE;
              if (!match) begin
                state_q  <= MEASURE;
                locked_q <= 1'b0;
              end
            end else if (expired) begin
              state_q      <= LOST;
              locked_q     <= 1'b0;
              timeout_q    <= 1'b1;
              prev_valid_q <= 1'b0;
            end
          end
          LOST: begin
            // The edge that ends a loss only restarts the interval.
            if (rise_ev) begin
              state_q   <= MEASURE;
              timeout_q <= 1'b0;
              cnt_q     <= CNT_ONE;
            end
          end
          default: begin
            state_q   <= IDLE;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rise_tick    = rise_tick_q;
  assign fall_tick    = fall_tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
